// File: rtl/dechannelizer_n_if.sv
// dechannelizer_n_if
//   Frame-in / beat-out stream bundle for dechannelizer_n.
//   slave  : the serialiser (consumes frames, produces beats)
//   master : the surrounding logic (produces frames, consumes beats)
//   in_data/in_valid/in_ready             : CHANNELS*WIDTH frame handshake
//   out_data/out_valid/out_ready          : WIDTH-bit beat handshake
//   out_sop/out_eop/out_channel           : beat framing and channel index
interface dechannelizer_n_if #(
    parameter int WIDTH    = 24,
    parameter int CHANNELS = 2
);
    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic [CHANNELS*WIDTH-1:0] in_data;
    logic                      in_valid;
    logic                      in_ready;
    logic [WIDTH-1:0]          out_data;
    logic                      out_valid;
    logic                      out_ready;
    logic                      out_sop;
    logic                      out_eop;
    logic [CW-1:0]             out_channel;

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid, out_sop, out_eop, out_channel
    );

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid, out_sop, out_eop, out_channel
    );
endinterface

// File: rtl/dechannelizer_n.sv
// dechannelizer_n
//   Captures one frame of CHANNELS parallel samples and emits it as a
//   CHANNELS-beat packet (sop on channel 0, eop on channel CHANNELS-1),
//   with output backpressure and zero-bubble back-to-back frames.
//   Ports:
//     clk, reset    : clock, asynchronous active-high reset
//     strm          : dechannelizer_n_if.slave (frame in, beat out)
//     overrun       : sticky "a frame was dropped"
//     drop_count    : saturating count of dropped frames
//     overrun_clr   : clears overrun and drop_count
//   Build option: define DECHANNELIZER_N_OVERRUN_EN to enable drop
//   accounting; otherwise overrun/drop_count are tied to 0.
module dechannelizer_n #(
    parameter int WIDTH    = 24,
    parameter int CHANNELS = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    dechannelizer_n_if.slave      strm,
    output logic                  overrun,
    output logic [15:0]           drop_count,
    input  logic                  overrun_clr
);
    localparam int            CW   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam logic [CW-1:0] LAST = CW'(CHANNELS - 1);

    logic [WIDTH-1:0] frame [CHANNELS];
    logic [CW-1:0]    idx;
    logic [CW-1:0]    nxt;
    logic             busy;
    logic             last;
    logic             accept;
    logic             beat;

    assign last = (idx == LAST);
    assign nxt  = idx + CW'(1);

    // Ready while idle, or when the final beat leaves this very cycle:
    // this is what lets eop be followed directly by the next sop.
    assign strm.in_ready = !reset && (!busy || (last && strm.out_ready));
    assign accept        = strm.in_valid && strm.in_ready;
    assign beat          = busy && strm.out_ready;
    assign strm.out_valid = busy;

    // Sample storage; written only on accept, so a dropped frame never
    // disturbs the packet in flight.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int k = 0; k < CHANNELS; k++)
                frame[k] <= strm.in_data[k*WIDTH +: WIDTH];
        end
    end

    // Beat sequencing with registered beat outputs. Channel 0 is taken
    // straight from the input bus on accept since frame[] is not yet loaded.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy             <= 1'b0;
            idx              <= '0;
            strm.out_data    <= '0;
            strm.out_channel <= '0;
            strm.out_sop     <= 1'b0;
            strm.out_eop     <= 1'b0;
        end else if (accept) begin
            busy             <= 1'b1;
            idx              <= '0;
            strm.out_data    <= strm.in_data[WIDTH-1:0];
            strm.out_channel <= '0;
            strm.out_sop     <= 1'b1;
            strm.out_eop     <= (CHANNELS == 1);
        end else if (beat) begin
            if (last) begin
                busy         <= 1'b0;
                strm.out_sop <= 1'b0;
                strm.out_eop <= 1'b0;
            end else begin
                idx              <= nxt;
                strm.out_data    <= frame[nxt];
                strm.out_channel <= nxt;
                strm.out_sop     <= 1'b0;
                strm.out_eop     <= (nxt == LAST);
            end
        end
    end

`ifdef DECHANNELIZER_N_OVERRUN_EN
    logic drop;
    assign drop = strm.in_valid && !strm.in_ready;

    // A drop in the same cycle as a clear restarts the count at 1.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overrun    <= 1'b0;
            drop_count <= '0;
        end else if (drop) begin
            overrun <= 1'b1;
            if (overrun_clr)
                drop_count <= 16'd1;
            else if (drop_count != 16'hFFFF)
                drop_count <= drop_count + 16'd1;
        end else if (overrun_clr) begin
            overrun    <= 1'b0;
            drop_count <= '0;
        end
    end
`else
    logic unused_overrun_clr;
    assign unused_overrun_clr = overrun_clr;
    assign overrun    = 1'b0;
    assign drop_count = '0;
`endif
endmodule

// File: tb/tb_dechannelizer_n.sv
// tb_dechannelizer_n
//   Drives three instances (2ch/24b, 4ch/24b, 1ch/8b) and compares every
//   cycle against a queue-of-pending-beats reference model.
module tb_dechannelizer_n;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset;

    dechannelizer_n_if #(.WIDTH(24), .CHANNELS(2)) if2 ();
    dechannelizer_n_if #(.WIDTH(24), .CHANNELS(4)) if4 ();
    dechannelizer_n_if #(.WIDTH(8),  .CHANNELS(1)) if1 ();

    logic [2:0]       iv, ordy, clr, ov;
    logic [2:0][15:0] dc;
    logic [31:0]      smp [3][16];
    logic [2:0]       rdy, vld, sop, eop;
    logic [2:0][31:0] od;
    logic [2:0][3:0]  och;

    dechannelizer_n #(.WIDTH(24), .CHANNELS(2)) u2 (
        .clk(clk), .reset(reset), .strm(if2.slave),
        .overrun(ov[0]), .drop_count(dc[0]), .overrun_clr(clr[0]));
    dechannelizer_n #(.WIDTH(24), .CHANNELS(4)) u4 (
        .clk(clk), .reset(reset), .strm(if4.slave),
        .overrun(ov[1]), .drop_count(dc[1]), .overrun_clr(clr[1]));
    dechannelizer_n #(.WIDTH(8), .CHANNELS(1)) u1 (
        .clk(clk), .reset(reset), .strm(if1.slave),
        .overrun(ov[2]), .drop_count(dc[2]), .overrun_clr(clr[2]));

    assign if2.in_valid = iv[0];  assign if2.out_ready = ordy[0];
    assign if4.in_valid = iv[1];  assign if4.out_ready = ordy[1];
    assign if1.in_valid = iv[2];  assign if1.out_ready = ordy[2];
    assign if2.in_data = {smp[0][1][23:0], smp[0][0][23:0]};
    assign if4.in_data = {smp[1][3][23:0], smp[1][2][23:0], smp[1][1][23:0], smp[1][0][23:0]};
    assign if1.in_data = smp[2][0][7:0];

    assign rdy = {if1.in_ready, if4.in_ready, if2.in_ready};
    assign vld = {if1.out_valid, if4.out_valid, if2.out_valid};
    assign sop = {if1.out_sop, if4.out_sop, if2.out_sop};
    assign eop = {if1.out_eop, if4.out_eop, if2.out_eop};
    assign od[0] = 32'(if2.out_data);
    assign od[1] = 32'(if4.out_data);
    assign od[2] = 32'(if1.out_data);
    assign och[0] = 4'(if2.out_channel);
    assign och[1] = 4'(if4.out_channel);
    assign och[2] = 4'(if1.out_channel);

    // Reference model: per instance, the beats still owed to the sink
    // (front = beat currently presented), each {channel, sample}.
    int          nch [3] = '{2, 4, 1};
    int          wd  [3] = '{24, 24, 8};
    logic [35:0] mq  [3][$];
    int          mcnt[3];
    bit          mov [3];
    bit          er  [3];
    int          tests = 0;
    int          fails = 0;

    task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit exp_rdy(input int d);
        if (reset) return 1'b0;
        return (mq[d].size() == 0) || (mq[d].size() == 1 && ordy[d]);
    endfunction

    task automatic set_frame(input int d);
        for (int k = 0; k < nch[d]; k++) smp[d][k] = $urandom;
    endtask

    task automatic model_edge();
        for (int d = 0; d < 3; d++) begin
            logic [31:0] mask;
            mask = 32'((64'd1 << wd[d]) - 64'd1);
            if (reset) begin
                mq[d].delete();
                mcnt[d] = 0;
                mov[d]  = 1'b0;
            end else begin
                if (mq[d].size() != 0 && ordy[d]) void'(mq[d].pop_front());
                if (iv[d] && er[d]) begin
                    for (int k = 0; k < nch[d]; k++)
                        mq[d].push_back({4'(k), smp[d][k] & mask});
                end
                if (iv[d] && !er[d]) begin
                    mov[d] = 1'b1;
                    if (clr[d])               mcnt[d] = 1;
                    else if (mcnt[d] < 65535) mcnt[d] = mcnt[d] + 1;
                end else if (clr[d]) begin
                    mov[d]  = 1'b0;
                    mcnt[d] = 0;
                end
            end
        end
    endtask

    task automatic check_outs();
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("out_valid[%0d]", d), 36'(vld[d]), 36'(mq[d].size() != 0));
            if (mq[d].size() != 0) begin
                logic [35:0] e;
                e = mq[d][0];
                chk($sformatf("out_data[%0d]", d), 36'(od[d]), 36'(e[31:0]));
                chk($sformatf("out_channel[%0d]", d), 36'(och[d]), 36'(e[35:32]));
                chk($sformatf("out_sop[%0d]", d), 36'(sop[d]), 36'(e[35:32] == 4'd0));
                chk($sformatf("out_eop[%0d]", d), 36'(eop[d]), 36'(int'(e[35:32]) == nch[d]-1));
            end else begin
                chk($sformatf("idle_sop[%0d]", d), 36'(sop[d]), 36'(0));
                chk($sformatf("idle_eop[%0d]", d), 36'(eop[d]), 36'(0));
            end
`ifdef DECHANNELIZER_N_OVERRUN_EN
            chk($sformatf("overrun[%0d]", d), 36'(ov[d]), 36'(mov[d]));
            chk($sformatf("drop_count[%0d]", d), 36'(dc[d]), 36'(mcnt[d]));
`else
            chk($sformatf("overrun_off[%0d]", d), 36'(ov[d]), 36'(0));
            chk($sformatf("drop_count_off[%0d]", d), 36'(dc[d]), 36'(0));
`endif
        end
    endtask

    // One clock: check ready mid-cycle, advance model at the edge,
    // check outputs just after it. Inputs change only after return.
    task automatic cycle();
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            er[d] = exp_rdy(d);
            chk($sformatf("in_ready[%0d]", d), 36'(rdy[d]), 36'(er[d]));
        end
        @(posedge clk);
        model_edge();
        #1;
        check_outs();
    endtask

    initial begin
        reset = 1'b1;
        iv = '0; ordy = '1; clr = '0;
        for (int d = 0; d < 3; d++) begin
            mcnt[d] = 0; mov[d] = 1'b0;
            for (int k = 0; k < 16; k++) smp[d][k] = '0;
        end

        // reset state
        cycle(); cycle();
        reset = 1'b0;
        cycle();

        // 2-channel directed frame
        smp[0][0] = 32'h123456; smp[0][1] = 32'h00BEEF;
        iv[0] = 1'b1;
        cycle();
        iv[0] = 1'b0;
        chk("tp1_data_ch0", 36'(od[0]), 36'h123456);
        cycle();
        chk("tp1_data_ch1", 36'(od[0]), 36'h00BEEF);
        cycle();
        chk("tp1_valid_after", 36'(vld[0]), 36'(0));

        // 4ch frames every 4 cycles, 1ch frames every cycle
        for (int i = 0; i < 16; i++) begin
            iv[1] = (i % 4 == 0);
            if (iv[1]) set_frame(1);
            iv[2] = 1'b1;
            set_frame(2);
            cycle();
        end
        iv = '0;
        cycle(); cycle(); cycle(); cycle();

        // stall 3 cycles on beat 2 of a 4ch packet
        set_frame(1); iv[1] = 1'b1;
        cycle();
        iv[1] = 1'b0;
        cycle(); cycle();
        ordy[1] = 1'b0;
        cycle(); cycle(); cycle();
        ordy[1] = 1'b1;
        cycle(); cycle(); cycle();

        // overrun: frames at T and T+2, then drop together with clear
        set_frame(1); iv[1] = 1'b1;
        cycle();
        iv[1] = 1'b0;
        cycle();
        set_frame(1); iv[1] = 1'b1;
        cycle();
        clr[1] = 1'b1;
        cycle();
        iv[1] = 1'b0; clr[1] = 1'b0;
        cycle(); cycle(); cycle();

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            for (int d = 0; d < 3; d++) begin
                iv[d]   = ($urandom_range(0, 99) < 45);
                ordy[d] = ($urandom_range(0, 99) < 70);
                clr[d]  = ($urandom_range(0, 99) < 4);
                set_frame(d);
            end
            cycle();
        end
        iv = '0; ordy = '1; clr = '0;
        for (int i = 0; i < 6; i++) cycle();

        // reset while beat 1 of a 4ch packet is presented
        set_frame(1); iv[1] = 1'b1;
        cycle();
        iv[1] = 1'b0;
        cycle();
        chk("pre_reset_channel", 36'(och[1]), 36'(1));
        reset = 1'b1;
        #1;
        chk("rst_valid", 36'(vld[1]), 36'(0));
        chk("rst_data", 36'(od[1]), 36'(0));
        chk("rst_channel", 36'(och[1]), 36'(0));
        chk("rst_sop", 36'(sop[1]), 36'(0));
        chk("rst_eop", 36'(eop[1]), 36'(0));
        chk("rst_in_ready", 36'(rdy[1]), 36'(0));
        for (int d = 0; d < 3; d++) begin
            mq[d].delete(); mcnt[d] = 0; mov[d] = 1'b0;
        end
        cycle();
        reset = 1'b0;
        set_frame(1); iv[1] = 1'b1;
        cycle();
        iv[1] = 1'b0;
        chk("post_reset_sop", 36'(sop[1]), 36'(1));
        for (int i = 0; i < 5; i++) cycle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/dechannelizer_n.md
# dechannelizer_n

Parametrised frame-to-stream serialiser for the DDC receive path. Captures one frame of CHANNELS parallel samples (one per DDC/decimator channel) and emits it as a packet of CHANNELS beats, with sop on channel 0 and eop on the last channel. It sits between the multi-channel decimation chain and the single-stream packet FIFO/interface logic. Adds to the fixed two-channel version:

- Full output backpressure.
- Zero-bubble back-to-back frames.
- Channel index on every beat.
- Optional overrun accounting.

## Interface
- WIDTH, 24, sample width in bits (8..32).
- CHANNELS, 2, channels per frame (1..16).
- CW, $clog2(CHANNELS) (min 1), width of channel index; derived, not overridden.

- clk  input  1  sole clock; all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_data  input  CHANNELS*WIDTH  frame; channel k at bits [k*WIDTH +: WIDTH].
- in_valid  input  1  frame present this cycle; source does not hold data, no backpressure honoured upstream.
- in_ready  output  1  frame accepted this cycle when in_valid && in_ready.
- out_data  output  WIDTH  current beat sample.
- out_valid  output  1  beat valid.
- out_ready  input  1  sink accepts beat when out_valid && out_ready.
- out_sop  output  1  beat is channel 0.
- out_eop  output  1  beat is channel CHANNELS-1.
- out_channel  output  CW  channel index of current beat.
- overrun  output  1  sticky: a frame was dropped.
- drop_count  output  16  dropped frames, saturating.
- overrun_clr  input  1  clears overrun and drop_count.

## Operation
- Internal state:
  - frame register: CHANNELS×WIDTH.
  - beat index idx: CW bits.
  - busy flag.
- States:
  - IDLE (busy=0).
  - SEND (busy=1, idx 0..CHANNELS-1).
- in_ready = !reset && (!busy || (idx==CHANNELS-1 && out_ready)).
  - Combinational from out_ready; no other combinational in→out path.
- Frame accept (in_valid && in_ready):
  - Load frame register.
  - idx←0, busy←1.
  - Next cycle presents channel 0.
- Beat accept (out_valid && out_ready):
  - idx<CHANNELS-1: idx←idx+1.
  - idx==CHANNELS-1, no new frame accepted: busy←0.
  - idx==CHANNELS-1, frame accepted same cycle: reload, idx←0, busy stays 1.
- Outputs are registered, derived from the frame register and idx:
  - out_valid=busy.
  - out_data=frame[idx].
  - out_channel=idx.
  - out_sop=busy && idx==0.
  - out_eop=busy && idx==CHANNELS-1.
- Outputs hold stable while out_valid && !out_ready.
- CHANNELS=1: single beat with sop=eop=1.
- Samples pass bit-exact; no arithmetic, no sign extension.
- Drop (in_valid && !in_ready): frame discarded; frame register and in-flight packet untouched.
- Reset mid-packet: packet truncated immediately, no eop emitted, next packet starts cleanly at channel 0.
- Reset values:
  - out_data=0, out_valid=0, out_sop=0, out_eop=0, out_channel=0.
  - overrun=0, drop_count=0.
  - busy=0, idx=0.
  - in_ready=0 while reset high, 1 the first cycle after.

## Timing
- Latency: frame accepted at cycle T → channel 0 valid at T+1.
- With out_ready=1, channel k appears at T+1+k.
- Throughput: one frame per CHANNELS cycles sustained, no idle cycle between eop and next sop.
- Stall: every cycle with out_ready=0 delays all later beats by one cycle.
- Minimum in_valid spacing without drops at full out_ready: CHANNELS cycles.

## Configuration
- DECHANNELIZER_N_OVERRUN_EN defined:
  - On each drop, overrun←1 and drop_count←drop_count+1 (saturating at 16'hFFFF).
  - overrun_clr clears both.
  - Simultaneous overrun_clr and drop: drop wins, giving overrun=1, drop_count=1.
- Not defined:
  - overrun and drop_count tied to 0.
  - overrun_clr ignored.
  - No counter logic synthesised.
  - Datapath behaviour identical.

## Test plan
- CHANNELS=2, WIDTH=24, out_ready=1: frame {ch1=24'h00BEEF, ch0=24'h123456} → T+1 sop, channel 0, 24'h123456; T+2 eop, channel 1, 24'h00BEEF; T+3 out_valid=0.
- CHANNELS=4: in_valid every 4 cycles, out_ready=1 → 4-beat packets contiguous, eop immediately followed by sop, in_ready high on each eop cycle, drop_count=0.
- CHANNELS=4: out_ready=0 for 3 cycles on beat 2 → beat 2 data, channel 2 and flags held stable; beats 2,3 follow once ready; total packet 7 cycles.
- OVERRUN_EN, CHANNELS=4: in_valid at T and T+2 → second frame dropped, overrun=1, drop_count=1, first packet intact; assert overrun_clr together with another drop → overrun=1, drop_count=1.
- CHANNELS=1: frame 8'h5A (WIDTH=8) → single beat with sop=eop=1, channel 0; back-to-back every cycle, no drops.
- Assert reset during beat 1 of a 4-channel packet → all outputs 0 asynchronously; after release, new frame starts at channel 0 with sop.
